// File: rtl/muldiv_pkg.sv
// Shared encodings and sizing helpers for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             div_mode,
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   acc_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        // acc[WIDTH] is always clear between multiply steps, so the add cannot overflow
        sum      = acc + {1'b0, (q[0] ? m : {WIDTH{1'b0}})};
        shifted  = {acc[WIDTH-1:0], q[WIDTH-1]};
        diff     = {1'b0, shifted} - {2'b00, m};
        acc_next = {1'b0, sum[WIDTH:1]};
        q_next   = {sum[0], q[WIDTH-1:1]};
        if (div_mode) begin
            if (!diff[WIDTH+1]) begin
                acc_next = diff[WIDTH:0];
                q_next   = {q[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = shifted;
                q_next   = {q[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; also services MTHI/MTLO.
// state | meaning:  IDLE | accept requests;  RUN | WIDTH radix-2 steps;  FIX | sign-correct, write HI/LO
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t state, state_next;

    logic [CNT_W-1:0]   cnt;
    logic [WIDTH:0]     acc, acc_step;
    logic [WIDTH-1:0]   q, q_step, m;
    logic               is_div, neg_q, neg_r, b_zero;
    logic               load, mt_hi, mt_lo, wr_res;
    logic               signed_op, mul_op;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        mt_hi      = 1'b0;
        mt_lo      = 1'b0;
        wr_res     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !cancel) begin
                    case (op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            load       = 1'b1;
                            state_next = RUN;
                        end
                        OP_MTHI: mt_hi = 1'b1;
                        OP_MTLO: mt_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cancel)                          state_next = IDLE;
                else if (cnt == CNT_W'(WIDTH - 1))  state_next = FIX;
            end
            FIX: begin
                state_next = IDLE;
                wr_res     = !cancel;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign mul_op    = (op == OP_MULT) || (op == OP_MULTU);
    assign a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div_mode (is_div),
        .acc      (acc),
        .q        (q),
        .m        (m),
        .acc_next (acc_step),
        .q_next   (q_step)
    );

    // A zero divisor leaves an all-ones quotient that must not be negated
    assign prod_raw = {acc[WIDTH-1:0], q};
    assign prod_fix = neg_q ? -prod_raw : prod_raw;
    assign quot_fix = (neg_q && !b_zero) ? -q : q;
    assign rem_fix  = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            q      <= '0;
            m      <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= wr_res;
            if (load) begin
                cnt    <= '0;
                acc    <= '0;
                q      <= mul_op ? b_mag : a_mag;
                m      <= mul_op ? a_mag : b_mag;
                is_div <= !mul_op;
                neg_q  <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r  <= signed_op && !mul_op && a[WIDTH-1];
                b_zero <= (b == '0);
            end else if (state == RUN) begin
                acc <= acc_step;
                q   <= q_step;
                cnt <= cnt + 1'b1;
            end
            if (mt_hi) hi <= a;
            if (mt_lo) lo <= a;
            if (wr_res) begin
                if (is_div) begin
                    hi <= rem_fix;
                    lo <= quot_fix;
                end else begin
                    {hi, lo} <= prod_fix;
                end
            end
        end
    end

endmodule
